// File: rtl/hash_share_arbiter.sv
// Purpose: shares one SHAKE hash core plus RAM between N_REQ requesters. Start
//          pulses are latched, the core is granted round-robin, and exactly one
//          o_hash_start is issued per grant.
// Latency: a start sampled in IDLE gives o_grant/o_hash_start 1 cycle later;
//          ack -> next o_hash_start takes at least 3 cycles (RELEASE, IDLE, START).
// Backpressure: requests that arrive while the core is owned wait in a pending
//          register. Data handshakes pass straight through to/from the owner.
//
// Ports (requester r owns slice [r*W +: W] of every packed per-requester vector):
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_req_*                    per-requester start, data, lengths, ready, force-done
//   o_req_*                    per-requester address, rd_en, digest data/valid, ack
//   o_hash_* / i_hash_*        the single shared core port
//   o_grant                    one-hot owner, 0 when idle
//   o_busy                     high whenever the FSM is outside IDLE
//   o_err                      sticky: owner pulsed start again while in START/BUSY
module hash_share_arbiter #(
    parameter int N_REQ    = 2,
    parameter int IO_WIDTH = 32,
    parameter int ADDR_W   = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,

    // Requester side
    input  logic [N_REQ-1:0]             i_req_start,
    input  logic [N_REQ*IO_WIDTH-1:0]    i_req_data_in,
    input  logic [N_REQ*32-1:0]          i_req_input_length,
    input  logic [N_REQ*32-1:0]          i_req_output_length,
    input  logic [N_REQ-1:0]             i_req_data_out_ready,
    input  logic [N_REQ-1:0]             i_req_force_done,
    output logic [N_REQ*ADDR_W-1:0]      o_req_addr,
    output logic [N_REQ-1:0]             o_req_rd_en,
    output logic [N_REQ*IO_WIDTH-1:0]    o_req_data_out,
    output logic [N_REQ-1:0]             o_req_data_out_valid,
    output logic [N_REQ-1:0]             o_req_force_done_ack,

    // Core side
    output logic [IO_WIDTH-1:0]          o_hash_data_in,
    input  logic [ADDR_W-1:0]            i_hash_addr,
    input  logic                         i_hash_rd_en,
    input  logic [IO_WIDTH-1:0]          i_hash_data_out,
    input  logic                         i_hash_data_out_valid,
    output logic                         o_hash_data_out_ready,
    output logic [31:0]                  o_hash_input_length,
    output logic [31:0]                  o_hash_output_length,
    output logic                         o_hash_start,
    output logic                         o_hash_force_done,
    input  logic                         i_hash_force_done_ack,

    // Status
    output logic [N_REQ-1:0]             o_grant,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] rr_next;

    assign req = pending_q | i_req_start;

    // Round-robin pick: first set bit of req scanning rr, rr+1, ... modulo N_REQ.
    // The sum is one bit wider than the index so the wrap works for N_REQ = 3.
    always_comb begin
        logic             found;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        win_oh = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Binary index of the current owner; grant_q is one-hot or zero.
    always_comb begin
        g_idx = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (grant_q[r]) begin
                g_idx = IDX_W'(r);
            end
        end
    end

    // Pointer moves to the requester after the one being released.
    always_comb begin
        logic [IDX_W:0] inc;
        inc = {1'b0, g_idx} + (IDX_W+1)'(1);
        if (inc >= (IDX_W+1)'(N_REQ)) begin
            rr_next = '0;
        end else begin
            rr_next = inc[IDX_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                pending_d = pending_q | i_req_start;
                if (|req) begin
                    grant_d = win_oh;
                    state_d = S_START;
                end
            end
            S_START, S_BUSY: begin
                // A restart from the owner is a protocol error and is dropped;
                // anyone else simply queues. Re-pulses from already pending
                // requesters merge into the same bit.
                pending_d = pending_q | (i_req_start & ~grant_q);
                if (|(i_req_start & grant_q)) begin
                    err_d = 1'b1;
                end
                if (state_q == S_START) begin
                    // The core cannot have finished a job it has not seen yet,
                    // so an ack here is ignored.
                    state_d = S_BUSY;
                end else if (i_hash_force_done_ack) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The owner's job is over, so a start it raises in this cycle
                // is a fresh request and is kept (set wins over clear).
                pending_d = (pending_q & ~grant_q) | i_req_start;
                rr_d      = rr_next;
                grant_d   = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
        end
    end

    // Routing: an AND-OR mux on the one-hot grant, so everything is 0 when idle
    // and only the owner's slices ever carry core traffic.
    always_comb begin
        o_hash_data_in        = '0;
        o_hash_input_length   = '0;
        o_hash_output_length  = '0;
        o_hash_data_out_ready = 1'b0;
        o_hash_force_done     = 1'b0;
        o_req_addr            = '0;
        o_req_rd_en           = '0;
        o_req_data_out        = '0;
        o_req_data_out_valid  = '0;
        o_req_force_done_ack  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (grant_q[r]) begin
                o_hash_data_in        = i_req_data_in[r*IO_WIDTH +: IO_WIDTH];
                o_hash_input_length   = i_req_input_length[r*32 +: 32];
                o_hash_output_length  = i_req_output_length[r*32 +: 32];
                o_hash_data_out_ready = i_req_data_out_ready[r];
                o_hash_force_done     = i_req_force_done[r];
                o_req_addr[r*ADDR_W +: ADDR_W]       = i_hash_addr;
                o_req_rd_en[r]                       = i_hash_rd_en;
                o_req_data_out[r*IO_WIDTH +: IO_WIDTH] = i_hash_data_out;
                o_req_data_out_valid[r]              = i_hash_data_out_valid;
                o_req_force_done_ack[r]              = i_hash_force_done_ack;
            end
        end
    end

    assign o_hash_start = (state_q == S_START);
    assign o_busy       = (state_q != S_IDLE);
    assign o_grant      = grant_q;
    assign o_err        = err_q;

endmodule
